uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
// - UART transmitter fed by baud_gen: serialises parallel words onto tx, one bit per baud tick.
// - Upstream producer (CPU/FIFO) hands words over a valid/ready handshake.
// - A single-entry holding register lets the next word be accepted while the current frame shifts out.
// - Frames go back-to-back with no idle gap.
// PARAMETERS
// - DATA_BITS  8  data bits per frame, legal 5..9, sent LSB first
// - PARITY     0  0=none, 1=odd, 2=even
// - STOP_BITS  1  stop bits, legal 1 or 2
// PORTS
// - clk       in   1          system clock (50 MHz)
// - rst_n     in   1          asynchronous, active-low reset
// - tick      in   1          baud strobe from baud_gen, single-cycle pulse once per bit period
// - in_data   in   DATA_BITS  word to send, sampled only on handshake
// - in_valid  in   1          producer has a word
// - in_ready  out  1          holding register empty; transfer when in_valid && in_ready at posedge clk
// - tx        out  1          serial line, idle high, registered output
// - busy      out  1          frame in progress (state != IDLE)
// - done      out  1          one-cycle pulse on the cycle the last stop bit ends
// BEHAVIOUR
// - Reset (async, rst_n=0), tx=1, in_ready=1, busy=0, done=0. State=IDLE, holding register empty, counters 0.
// - Reset mid-frame abandons the frame and discards any held word. tx returns high immediately, not on a clock edge.
// - in_ready = !hold_full, driven from a flop. A word accepted on cycle N sets hold_full at N+1.
// - States advance only on clk edges where tick=1. All tx changes are registered on tick edges.
// - The bit period equals the tick interval. tick every cycle (dvsr=1) must work.
// - Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS ticks.
// - IDLE: on tick with hold_full, do all of the following:
//   - load shifter and parity from the holding register and clear hold_full;
//   - set tx<=0 (start bit) and go to START.
//   - Tick on the acceptance cycle itself does not start a frame; the next tick does.
// - START: on tick, tx<=shift[0], bit_cnt<=0, go to DATA.
// - DATA: on tick:
//   - if bit_cnt==DATA_BITS-1, go to PARITY with tx<=par, or (no parity) go to STOP with tx<=1, stop_cnt<=0;
//   - otherwise shift right, tx<=next bit, bit_cnt++.
// - PARITY: on tick, tx<=1, stop_cnt<=0, go to STOP.
//   - Even parity: par = ^data. Odd parity: par = ~^data. Computed on the loaded word.
// - STOP: on tick:
//   - if stop_cnt==STOP_BITS-1, pulse done. Then if hold_full, reload and tx<=0, go to START (no gap); else tx<=1, go to IDLE.
//   - otherwise stop_cnt++.
// - Simultaneous: a load (hold emptied) and an accept cannot occur in the same cycle, since in_ready=0 while full.
//   in_ready reasserts the cycle after a load.
// - in_data/in_valid changes without ready are ignored. tick high for more than one cycle counts once per cycle (producer's error).
// - Illegal parameter values stop elaboration ($error / generate guard).
// STRUCTURE
// - Shared package uart_pkg: FSM state encodings (IDLE/START/DATA/PARITY/STOP) and PARITY_NONE/ODD/EVEN constants.
//   The same encodings are reused by uart_rx.
// - One natural sub-module: uart_tx_hold, the single-entry valid/ready holding register (data + full flag).
// - FSM, shifter, bit/stop counters and the parity flop stay in uart_tx.
// TESTING
// - Reset: rst_n=0 -> tx=1, in_ready=1, busy=0, done=0. Hold for 3 clocks with tick toggling -> no change.
// - 8N1, tick every 4 clks, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
//   Each bit holds exactly 4 clks; done pulses once; busy falls with done.
// - Back-to-back: in_valid held with 0x00 then 0xFF -> second word accepted during the first frame's DATA.
//   Stop bit of frame 1 is followed immediately by the start bit of frame 2; in_ready low while held.
// - Parity with 0x07, 8 data bits -> PARITY=2 sends parity bit 1; PARITY=1 sends 0. Frame = 11 ticks.
// - STOP_BITS=2 with tick every cycle -> two high bit periods, then done; 0x3C serialises correctly at dvsr=1.
// - Reset mid-DATA (after 3 data bits) -> tx=1 before next posedge, busy=0, in_ready=1.
//   The next word 0x55 then transmits as a clean, full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (also used by uart_rx),
// parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Parity bit for a word of up to 9 bits; unused upper bits must be zero.
  function automatic logic parity_of(input int mode, input logic [8:0] word);
    return (mode == PARITY_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// Single-entry valid/ready holding register in front of the transmitter.
// in_ready comes straight from the full flop, so a word accepted on cycle N
// shows up as full (and ready low) from cycle N+1.
module uart_tx_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         pop,
  output logic [W-1:0] hold_data,
  output logic         hold_full
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  // Capture a word on handshake, release it when the transmitter loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (pop) begin
      full_reg <= 1'b0;
    end else if (in_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end

  assign in_ready  = ~full_reg;
  assign hold_data = data_reg;
  assign hold_full = full_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits. One bit per baud tick, frames run back-to-back
// when the holding register already has the next word.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int                 CNT_W      = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_BITS - 1);
  localparam logic               LAST_STOP  = 1'(STOP_BITS - 1);
  localparam bit                 HAS_PARITY = (PARITY != PARITY_NONE);

  uart_state_e            state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   stop_cnt_reg, stop_cnt_next;
  logic                   par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic                   done_reg, done_next;
  logic                   load;
  logic [DATA_BITS-1:0]   hold_data;
  logic                   hold_full;

  uart_tx_hold #(.W(DATA_BITS)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop       (load),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  // State, datapath and the registered serial line; tx idles high in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      par_reg      <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      par_reg      <= par_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic; everything advances only on a baud tick.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    par_next      = par_reg;
    tx_next       = tx_reg;
    done_next     = 1'b0;
    load          = 1'b0;
    if (tick) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (hold_full) begin
            load       = 1'b1;
            shift_next = hold_data;
            par_next   = parity_of(PARITY, 9'(hold_data));
            tx_next    = 1'b0;
            state_next = ST_START;
          end
        end
        ST_START: begin
          tx_next      = shift_reg[0];
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_reg == LAST_BIT) begin
            if (HAS_PARITY) begin
              tx_next    = par_reg;
              state_next = ST_PARITY;
            end else begin
              tx_next       = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = ST_STOP;
            end
          end else begin
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        ST_PARITY: begin
          tx_next       = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            done_next = 1'b1;
            if (hold_full) begin
              // Next word is waiting: its start bit follows with no idle gap.
              load       = 1'b1;
              shift_next = hold_data;
              par_next   = parity_of(PARITY, 9'(hold_data));
              tx_next    = 1'b0;
              state_next = ST_START;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
        default: begin
          tx_next    = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

endmodule
